hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/md_busy_timer.sv | 58 +++++
 rtl/hazard_unit.sv | 72 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: mult/div FSM encoding, default latencies and register-compare helper.
package pipeline_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned STALL_CNT_W     = 32;
  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // True when a nonzero destination register feeds the given source register.
  function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit occupancy timer: goes busy for a fixed number of cycles per MULT/DIV start.
module md_busy_timer
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while already busy is ignored; the HI/LO interlock keeps it from happening.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use, branch-operand and HI/LO interlocks plus stall accounting.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       IF_ID_RegisterRs,
  input  logic [REG_W-1:0]       IF_ID_RegisterRt,
  input  logic                   IF_ID_UsesRt,
  input  logic                   IF_ID_Branch,
  input  logic                   IF_ID_BranchTaken,
  input  logic                   IF_ID_Jump,
  input  logic                   IF_ID_HiLoUse,
  input  logic                   ID_EX_MemRead,
  input  logic                   ID_EX_RegWrite,
  input  logic [REG_W-1:0]       ID_EX_RegWriteDst,
  input  logic                   ID_EX_MdStart,
  input  logic                   ID_EX_MdIsDiv,
  input  logic                   EX_MEM_MemRead,
  input  logic [REG_W-1:0]       EX_MEM_RegWriteDst,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   MdBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic lu_hazard, be_hazard, bm_hazard, hl_hazard, stall;

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (ID_EX_MdStart),
    .is_div(ID_EX_MdIsDiv),
    .busy  (MdBusy)
  );

  assign ex_rs  = reg_match(ID_EX_RegWriteDst, IF_ID_RegisterRs);
  assign ex_rt  = reg_match(ID_EX_RegWriteDst, IF_ID_RegisterRt) && IF_ID_UsesRt;
  assign mem_rs = reg_match(EX_MEM_RegWriteDst, IF_ID_RegisterRs);
  assign mem_rt = reg_match(EX_MEM_RegWriteDst, IF_ID_RegisterRt) && IF_ID_UsesRt;

  // Jumps only ever source Rs; branches may source both operands.
  assign lu_hazard = ID_EX_MemRead && (ex_rs || ex_rt);
  assign be_hazard = ID_EX_RegWrite &&
                     ((IF_ID_Branch && (ex_rs || ex_rt)) || (IF_ID_Jump && ex_rs));
  assign bm_hazard = IF_ID_Branch && EX_MEM_MemRead && (mem_rs || mem_rt);
  assign hl_hazard = IF_ID_HiLoUse && MdBusy;
  assign stall     = lu_hazard || be_hazard || bm_hazard || hl_hazard;

  assign PC_Write    = !stall;
  assign IF_ID_Write = !stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = !stall && (IF_ID_Jump || (IF_ID_Branch && IF_ID_BranchTaken));

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (stall) begin
      StallCount <= StallCount + STALL_CNT_W'(1);
    end
  end

endmodule
